// File: rtl/mem_arbiter_pkg.sv
// cpu_pkg: shared types and requester indices for the memory arbiter.
package cpu_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_LOAD  = 2;
    localparam int NUM_REQ   = 3;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshake plus memory macro port of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    import cpu_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, searching from last_gnt+1 mod 3.
module rr_pick
    import cpu_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [1:0]         last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         idx,
    output logic               valid
);
    logic [1:0] p0, p1, p2;

    always_comb begin
        p0 = last_gnt >= 2'd2 ? 2'd0 : last_gnt + 2'd1;
        p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
        p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
        valid = |eligible;
        idx = eligible[p0] ? p0 : eligible[p1] ? p1 : p2;
        gnt = valid ? 3'b001 << idx : 3'b000;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port synchronous memory
// between fetch, data and loader requesters via a req/ack handshake.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]         state;
    logic [1:0]         last_gnt;
    logic [1:0]         pick_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_valid;
    logic               issue;
    logic               done;
    logic               h_we;
    logic [ADDR_W-1:0]  h_addr;
    logic [DATA_W-1:0]  h_wdata;

    assign issue = state == S_ISSUE;
    assign done  = state == S_DONE;
    // The requester just served is excluded so DONE can hand over directly.
    assign eligible = done ? bus.req & ~gnt : state == S_IDLE ? bus.req : '0;

    rr_pick u_pick (
        .eligible (eligible),
        .last_gnt (last_gnt),
        .gnt      (pick_gnt),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gnt      <= '0;
            last_gnt <= 2'd2;
            h_we     <= 1'b0;
            h_addr   <= '0;
            h_wdata  <= '0;
        end else if (issue) begin
            state <= S_DONE;
        end else if (pick_valid) begin
            state    <= S_ISSUE;
            gnt      <= pick_gnt;
            last_gnt <= pick_idx;
            h_we     <= bus.we[pick_idx];
            h_addr   <= bus.addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            h_wdata  <= bus.wdata[int'(pick_idx)*DATA_W +: DATA_W];
        end else begin
            state <= S_IDLE;
            gnt   <= '0;
        end
    end

    assign bus.mem_en    = issue;
    assign bus.mem_we    = issue & h_we;
    assign bus.mem_addr  = issue ? h_addr : '0;
    assign bus.mem_wdata = issue ? h_wdata : '0;
    assign bus.ack       = done ? gnt : '0;
    assign bus.rdata     = done ? bus.mem_rdata : '0;
    assign bus.busy      = state != S_IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level round-robin model with its own copy of memory.
module tb_mem_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [32];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    // Memory macro: synchronous single port, read data one cycle after mem_en.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    logic [DW-1:0] ref_mem [32];
    int            m_left;
    int            m_cur;
    int            m_last;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rd;

    // m_left counts cycles until the current access is complete: 2 = memory
    // cycle in flight, 1 = ack cycle, 0 = nothing outstanding.
    task automatic model_step();
        logic [2:0] el;
        el = m_left == 0 ? bus.req : m_left == 1 ? bus.req & ~(3'b001 << m_cur) : 3'b000;
        if (m_left == 2) begin
            m_left = 1;
            if (m_we) ref_mem[m_addr] = m_wdata;
            else m_rd = ref_mem[m_addr];
        end else begin
            m_left = 0;
            for (int o = 1; o <= 3; o++) begin
                int j;
                j = (m_last + o) % 3;
                if (el[j] && m_left == 0) begin
                    m_left = 2;
                    m_cur = j;
                    m_last = j;
                    m_we = bus.we[j];
                    m_addr = bus.addr[j*AW +: AW];
                    m_wdata = bus.wdata[j*DW +: DW];
                end
            end
        end
    endtask

    task automatic drain();
        bus.req = '0;
        for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL drain: busy=%b want 0 after 20 cycles", bus.busy); end
    endtask

    task automatic test_reset();
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            pre_en = 1'b1; pre_addr = AW'(a); pre_data = DW'($urandom);
            ref_mem[a] = pre_data;
            @(posedge clk); #1;
        end
        pre_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.ack !== 3'b000 || bus.mem_en !== 1'b0)
            begin errors++; $display("FAIL reset_idle: busy=%b ack=%b mem_en=%b want 0", bus.busy, bus.ack, bus.mem_en); end
        @(posedge clk); #1;
        bus.req = 3'b111;
        bus.addr = {5'd3, 5'd2, 5'd1};
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.ack !== 3'b000)
            begin errors++; $display("FAIL reset_async_ctl: mem_en=%b mem_we=%b ack=%b want 0", bus.mem_en, bus.mem_we, bus.ack); end
        checks++; if (bus.busy !== 1'b0 || bus.mem_addr !== 5'd0 || bus.mem_wdata !== 8'd0 || bus.rdata !== 8'd0)
            begin errors++; $display("FAIL reset_async_data: busy=%b addr=%h wdata=%h rdata=%h want 0", bus.busy, bus.mem_addr, bus.mem_wdata, bus.rdata); end
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 5'd1)
            begin errors++; $display("FAIL reset_first_issue: mem_en=%b addr=%h want 1 01", bus.mem_en, bus.mem_addr); end
        @(negedge clk);
        checks++; if (bus.ack !== 3'b001) begin errors++; $display("FAIL reset_first_grant: ack=%b want 001", bus.ack); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_random();
        logic [2:0] seen, exp_ack;
        bus.req = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        m_left = 0; m_last = 2; m_cur = 0; seen = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!bus.req[i] || seen[i]) begin
                    bus.req[i] = $urandom_range(0, 2) != 0;
                    bus.we[i] = 1'($urandom);
                    bus.addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                    bus.wdata[i*DW +: DW] = DW'($urandom);
                end
            end
            @(negedge clk);
            exp_ack = m_left == 1 ? 3'b001 << m_cur : 3'b000;
            checks++; if (bus.ack !== exp_ack)
                begin errors++; $display("FAIL rand_ack c=%0d: got %b want %b", c, bus.ack, exp_ack); end
            checks++; if (bus.busy !== (m_left != 0) || bus.mem_en !== (m_left == 2))
                begin errors++; $display("FAIL rand_state c=%0d: busy=%b mem_en=%b want %b %b", c, bus.busy, bus.mem_en, m_left != 0, m_left == 2); end
            checks++; if (bus.mem_we !== (m_left == 2 && m_we) || bus.mem_addr !== (m_left == 2 ? m_addr : 5'd0)
                          || bus.mem_wdata !== (m_left == 2 ? m_wdata : 8'd0))
                begin errors++; $display("FAIL rand_mem c=%0d: we=%b addr=%h wdata=%h want %b %h %h", c, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                         m_left == 2 && m_we, m_left == 2 ? m_addr : 5'd0, m_left == 2 ? m_wdata : 8'd0); end
            if (m_left != 1) begin
                checks++; if (bus.rdata !== 8'd0) begin errors++; $display("FAIL rand_rdata_idle c=%0d: got %h want 00", c, bus.rdata); end
            end else if (!m_we) begin
                checks++; if (bus.rdata !== m_rd) begin errors++; $display("FAIL rand_rdata c=%0d: got %h want %h", c, bus.rdata, m_rd); end
            end
            seen = bus.ack;
            @(posedge clk);
            model_step();
            #1;
        end
        drain();
    endtask

    task automatic test_single_read();
        pre_en = 1'b1; pre_addr = 5'd5; pre_data = 8'h3C;
        @(posedge clk); #1;
        pre_en = 1'b0;
        bus.req = 3'b010; bus.we = 3'b000; bus.addr = {5'd0, 5'd5, 5'd0};
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 5'd5)
            begin errors++; $display("FAIL read_issue: en=%b we=%b addr=%h want 1 0 05", bus.mem_en, bus.mem_we, bus.mem_addr); end
        @(negedge clk);
        checks++; if (bus.ack !== 3'b010 || bus.rdata !== 8'h3C)
            begin errors++; $display("FAIL read_done: ack=%b rdata=%h want 010 3c", bus.ack, bus.rdata); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_write_read();
        bus.req = 3'b100; bus.we = 3'b100; bus.addr = {5'd31, 5'd0, 5'd0}; bus.wdata = {8'hA5, 8'h00, 8'h00};
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'd31 || bus.mem_wdata !== 8'hA5)
            begin errors++; $display("FAIL write_issue: we=%b addr=%h wdata=%h want 1 1f a5", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        @(negedge clk);
        checks++; if (bus.ack !== 3'b100) begin errors++; $display("FAIL write_ack: ack=%b want 100", bus.ack); end
        @(posedge clk); #1;
        bus.req = 3'b001; bus.we = 3'b000; bus.addr = {5'd0, 5'd0, 5'd31};
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.ack !== 3'b001 || bus.rdata !== 8'hA5)
            begin errors++; $display("FAIL readback: ack=%b rdata=%h want 001 a5", bus.ack, bus.rdata); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_contention();
        logic [2:0] exp_ack;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.req = 3'b111; bus.we = 3'b000;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp_ack = c % 2 == 0 ? 3'b001 << (c / 2 - 1) : 3'b000;
            checks++; if (bus.ack !== exp_ack || bus.busy !== 1'b1)
                begin errors++; $display("FAIL contention c=%0d: ack=%b busy=%b want %b 1", c, bus.ack, bus.busy, exp_ack); end
            @(posedge clk); #1;
            if (c % 2 == 0) bus.req[c / 2 - 1] = 1'b0;
        end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL contention_end: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_ack;
        bus.req = 3'b011; bus.we = 3'b000;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            exp_ack = c % 2 == 1 ? 3'b000 : (c / 2) % 2 == 1 ? 3'b001 : 3'b010;
            checks++; if (bus.ack !== exp_ack)
                begin errors++; $display("FAIL fairness c=%0d: ack=%b want %b", c, bus.ack, exp_ack); end
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_abort();
        bus.req = 3'b010; bus.we = 3'b010; bus.addr = {5'd0, 5'd7, 5'd0}; bus.wdata = {8'h00, 8'h5A, 8'h00};
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 5'd7)
            begin errors++; $display("FAIL abort_issue: en=%b we=%b addr=%h want 1 1 07", bus.mem_en, bus.mem_we, bus.mem_addr); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL abort_drop: en=%b we=%b busy=%b want 0", bus.mem_en, bus.mem_we, bus.busy); end
        @(negedge clk);
        checks++; if (bus.ack !== 3'b000) begin errors++; $display("FAIL abort_noack: ack=%b want 000", bus.ack); end
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 5'd7 || bus.ack !== 3'b000)
            begin errors++; $display("FAIL abort_reissue: en=%b addr=%h ack=%b want 1 07 000", bus.mem_en, bus.mem_addr, bus.ack); end
        @(negedge clk);
        checks++; if (bus.ack !== 3'b010) begin errors++; $display("FAIL abort_ack: ack=%b want 010", bus.ack); end
        @(posedge clk); #1;
        drain();
    endtask

    initial begin
        test_reset();
        test_random();
        test_single_read();
        test_write_read();
        test_contention();
        test_fairness();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing one single-port synchronous memory between three requesters: CPU instruction fetch, CPU data access, and the external program loader. Sits between the CPU control/datapath and the memory macro. Replaces direct memory enables with a req/ack handshake, so instruction fetch, data access and loading never collide. Each access is a single read or write with fixed, bounded latency.

## Interface
- ADDR_W, 5, word address width
- DATA_W, 8, data word width
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- req  in  3  per-requester request; bit 0 fetch, bit 1 data, bit 2 loader
- we  in  3  per-requester write flag, sampled with req
- addr  in  3*ADDR_W  per-requester address, slice i = requester i
- wdata  in  3*DATA_W  per-requester write data, slice i = requester i
- ack  out  3  one-hot completion pulse, one cycle
- rdata  out  DATA_W  read data, valid only while ack is nonzero
- busy  out  1  high in ISSUE and DONE
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0

## Operation
- States:
  - IDLE: no access in progress.
  - ISSUE: memory cycle driven.
  - DONE: memory data returned and the requester is acked.
- Arbitration: round-robin over eligible requests. Search order starts at last_gnt+1 mod 3. last_gnt resets to 2, so requester 0 has first priority after reset.
- IDLE:
  - If any req is set, at the clock edge: register the winner one-hot into gnt, capture its we/addr/wdata into holding registers, update last_gnt, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_en=1.
  - mem_we, mem_addr and mem_wdata come from the holding registers.
  - Next state is DONE unconditionally.
- DONE:
  - ack = gnt.
  - rdata = mem_rdata (pass-through). Write acks also drive rdata; the requester ignores it.
  - Arbitrate among req & ~gnt. If a winner exists, capture it and go directly to ISSUE; otherwise go to IDLE.
- Requester rules:
  - Hold req/we/addr/wdata stable until ack.
  - Drop req in the cycle after ack, or keep it high to request again. A request still high after ack is a new request.
- No request is ever dropped. A held req is granted within 2 other grants (4 ISSUE+DONE cycles).
- Outside ISSUE:
  - mem_en=0 and mem_we=0.
  - mem_addr and mem_wdata are 0.
- Outside DONE: ack=0 and rdata=0.
- Requests with we=1 never produce read data. The memory performs the write in the ISSUE cycle.

## Timing
- Latency: req sampled at edge k (state IDLE) gives ISSUE during cycle k+1 and ack during cycle k+2.
- Sustained throughput: one access per 2 cycles when a different requester is waiting at DONE.
- Sustained throughput for a single requester re-requesting alone: one access per 3 cycles (DONE, IDLE, ISSUE).
- Reset values:
  - state = IDLE, gnt = 0, last_gnt = 2, holding registers = 0.
  - All outputs 0.
- Reset mid-operation: assertion in ISSUE or DONE forces mem_en, mem_we and ack low immediately (asynchronous). The aborted access is never acked. The requester re-requests after reset.
- Simultaneous events:
  - All three requests arriving in the same IDLE cycle are served in order 0, 1, 2 after reset.
  - A requester dropping req in the same cycle it would win loses nothing. Arbitration only looks at the current cycle's req.
- busy equals (state != IDLE) and is registered-state derived, glitch-free.

## Structure
- Shared package cpu_pkg holds:
  - enum arb_state_e {IDLE, ISSUE, DONE}, 2-bit encoding.
  - Constants REQ_FETCH=0, REQ_DATA=1, REQ_LOAD=2, NUM_REQ=3.
- One sub-module, rr_pick: purely combinational. Inputs: 3-bit eligible mask and 2-bit last_gnt. Outputs: one-hot grant, 2-bit index and valid.
- mem_arbiter holds the FSM, the holding registers, last_gnt and the output muxing.

## Test plan
- Reset: assert rst mid-cycle with req=3'b111 → all outputs 0 immediately; after release, the first grant goes to requester 0.
- Single read: memory holds 8'h3C at address 5. req[1]=1, we[1]=0, addr slice 1=5 at edge k → mem_en=1 and mem_addr=5 in cycle k+1; ack=3'b010 and rdata=8'h3C in cycle k+2.
- Write then read: requester 2 writes 8'hA5 to address 31 → mem_we=1 in ISSUE, then ack=3'b100. Requester 0 then reads address 31 and gets rdata=8'hA5.
- Three-way contention: req=3'b111 held after reset → acks 3'b001, 3'b010, 3'b100 on cycles k+2, k+4 and k+6; busy stays high throughout.
- Fairness: req[0] and req[1] both held continuously for 8 accesses → acks alternate 001, 010, 001, 010 and so on. Neither requester waits more than 4 cycles.
- Abort: rst asserted during ISSUE of a write to address 7 → mem_en drops the same cycle and no ack appears. After release, the pending req[1] is re-granted with full latency.
